// File: rtl/lzc24_pkg.sv
// lzc24_pkg: shared widths and the default all-zero count for the 24-bit leading-zero counter
package lzc24_pkg;
    localparam int LZC_W         = 24;
    localparam int LZC_CNT_W     = 5;
    localparam int NIBBLES       = 6;
    localparam int ZERO_CODE_DEF = 24;
endpackage

// File: rtl/lzc_nibble.sv
// lzc_nibble: combinational 4-bit leading-zero encoder (n: nibble in, cnt: 0..3 zeros, nz: nibble nonzero)
module lzc_nibble (
    input  logic [3:0] n,
    output logic [1:0] cnt,
    output logic       nz
);
    always_comb begin
        cnt = n[3] ? 2'd0 : n[2] ? 2'd1 : n[1] ? 2'd2 : 2'd3;
        nz  = |n;
    end
endmodule

// File: rtl/lzc24_pipe.sv
// lzc24_pipe: registered 24-bit leading-zero counter; LZC24_PIPE_EN adds a nibble register stage (latency 2)
// ports: clk, reset (async active-high), i_valid/i_x in; o_valid, o_z (count), o_zero (input all zeros) out
module lzc24_pipe
    import lzc24_pkg::*;
#(
    parameter int ZERO_CODE = ZERO_CODE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [LZC_W-1:0]     i_x,
    output logic                 o_valid,
    output logic [LZC_CNT_W-1:0] o_z,
    output logic                 o_zero
);
    logic [NIBBLES-1:0][1:0] cnt, cnt_s;
    logic [NIBBLES-1:0]      nz, nz_s;
    logic                    v_s;
    logic [LZC_CNT_W-1:0]    z;

    // nibble 0 is the most significant
    for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
        lzc_nibble u_nib (
            .n   (i_x[LZC_W-1-4*g -: 4]),
            .cnt (cnt[g]),
            .nz  (nz[g])
        );
    end

`ifdef LZC24_PIPE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_s   <= 1'b0;
            cnt_s <= '0;
            nz_s  <= '0;
        end else begin
            v_s <= i_valid;
            if (i_valid) begin
                cnt_s <= cnt;
                nz_s  <= nz;
            end
        end
    end
`else
    assign v_s   = i_valid;
    assign cnt_s = cnt;
    assign nz_s  = nz;
`endif

    // scanning upward lets the most significant nonzero nibble overwrite the rest
    always_comb begin
        z = LZC_CNT_W'(ZERO_CODE);
        for (int k = NIBBLES - 1; k >= 0; k--)
            if (nz_s[k]) z = LZC_CNT_W'(4 * k) + {3'b0, cnt_s[k]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_z     <= '0;
            o_zero  <= 1'b0;
        end else begin
            o_valid <= v_s;
            if (v_s) begin
                o_z    <= z;
                o_zero <= ~|nz_s;
            end
        end
    end
endmodule

// File: tb/tb_lzc24_pipe.sv
// tb_lzc24_pipe: scoreboard bench for lzc24_pipe with directed vectors; latency follows LZC24_PIPE_EN
module tb_lzc24_pipe;
`ifdef LZC24_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [4:0] z;
        logic       zero;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [23:0] i_x = '0;
    logic        o_valid;
    logic [4:0]  o_z;
    logic        o_zero;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [4:0]  last_z;
    logic        last_zero;
    logic        have_last = 1'b0;

    lzc24_pipe dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_x     (i_x),
        .o_valid (o_valid),
        .o_z     (o_z),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            have_last = 1'b0;
        end else if (o_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got z=%0d zero=%0b at cycle %0d, want no output", o_z, o_zero, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (o_z !== e.z || o_zero !== e.zero || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL result: got z=%0d zero=%0b cycle=%0d, want z=%0d zero=%0b cycle=%0d",
                             o_z, o_zero, cyc, e.z, e.zero, e.cyc);
                end
            end
            last_z    = o_z;
            last_zero = o_zero;
            have_last = 1'b1;
        end else if (have_last) begin
            n_cmp++;
            if (o_z !== last_z || o_zero !== last_zero) begin
                n_bad++;
                $display("FAIL hold: got z=%0d zero=%0b, want z=%0d zero=%0b", o_z, o_zero, last_z, last_zero);
            end
        end
    end

    task automatic send(input logic [23:0] x, input logic [4:0] z, input logic zero);
        i_valid = 1'b1;
        i_x     = x;
        q.push_back('{z: z, zero: zero, cyc: cyc + LAT});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_x     = 24'($urandom);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(24'h000000, 5'd24, 1'b1);
        send(24'hFFFFFF, 5'd0, 1'b0);
        send(24'h000000, 5'd24, 1'b1);
        idle(4);

        // reset lands just after the 0x123456 sample edge; it must never emerge
        i_valid = 1'b1;
        i_x     = 24'h123456;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_z !== 5'd0 || o_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%0b z=%0d zero=%0b, want 0 0 0", o_valid, o_z, o_zero);
        end
        repeat (2) @(negedge clk);
        i_valid = 1'b0;
        reset   = 1'b0;
        idle(4);

        for (int k = 23; k >= 0; k--) send(24'd1 << k, 5'(23 - k), 1'b0);
        idle(3);

        send(24'h0F0000, 5'd4, 1'b0);
        send(24'h00F000, 5'd8, 1'b0);
        send(24'h000008, 5'd20, 1'b0);
        send(24'h0007FF, 5'd13, 1'b0);
        send(24'h001000, 5'd11, 1'b0);
        send(24'h000800, 5'd12, 1'b0);
        send(24'h800000, 5'd0, 1'b0);
        send(24'h000000, 5'd24, 1'b1);
        send(24'hFFFFFF, 5'd0, 1'b0);
        idle(3);

        send(24'h400000, 5'd1, 1'b0);
        idle(1);
        send(24'h000003, 5'd22, 1'b0);
        send(24'h010000, 5'd7, 1'b0);
        idle(4);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d results still pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lzc24_pipe.md
Name: lzc24_pipe

Overview:
- Registered 24-bit leading-zero counter.
- Returns the number of leading zeros, MSB first, of a 24-bit unsigned word as a 5-bit count.
- Used by the Q12.12 reciprocal datapath to normalise a magnitude into [0.5,1).
- Also flags an all-zero input so downstream saturation logic can act on it.

Parameters:
- ZERO_CODE, default 24: count driven on o_z when the input is all zeros. Must be 0..31.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_x is valid this cycle.
- i_x  input  24  unsigned word to analyse; bit 23 is the MSB.
- o_valid  output  1  o_z and o_zero are valid.
- o_z  output  5  leading-zero count of the captured i_x.
- o_zero  output  1  captured i_x was all zeros.

Behaviour:
- Count rule:
  - o_z = 23 − (index of the highest set bit of i_x).
  - i_x = 0x800000..0xFFFFFF gives 0. i_x = 0x000001 gives 23. i_x = 0 gives ZERO_CODE with o_zero = 1.
  - o_zero = 0 whenever any bit is set.
- Pure function of one input word; no state carries between samples.
- Timing:
  - Default latency is 1 cycle: i_x is sampled on the edge where i_valid = 1.
  - o_z, o_zero and o_valid = 1 appear in the registers after that edge.
  - o_valid follows i_valid delayed by the latency.
- Holding: o_z and o_zero hold their last value while i_valid = 0. Only o_valid drops.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs. No stall and no backpressure.
- Reset, asserted at any time:
  - Immediately forces o_valid = 0, o_z = 0, o_zero = 0, and clears any internal pipeline stage.
  - Samples in flight when reset asserts are discarded.
  - The first sample accepted after reset deasserts is the one on the first rising edge with reset low and i_valid = 1.
- Arithmetic: unsigned only; no sign handling (the caller supplies the magnitude).
- Structure: a priority tree over six 4-bit nibbles.
  - Nibble k covers bits [23−4k : 20−4k].
  - Result = 4·(index of first nonzero nibble) + count within that nibble.
  - All nibbles zero selects ZERO_CODE.

Optional Feature:
- Macro LZC24_PIPE_EN.
- When defined:
  - An extra register stage sits between the nibble stage and the final selection.
  - It holds six 2-bit nibble counts plus six nibble-nonzero flags.
  - Latency becomes 2 cycles, o_valid is delayed 2 cycles, and the stage is cleared by reset.
- When undefined: single register stage, latency 1.
- Count values are identical in both builds.

Decomposition:
- Shared package lzc24_pkg holds:
  - LZC_W = 24
  - LZC_CNT_W = 5
  - NIBBLES = 6
  - the ZERO_CODE default value
- One sub-module, lzc_nibble:
  - Combinational 4-bit encoder.
  - Outputs: a 2-bit leading-zero count (0..3) and a nonzero flag.
  - Instantiated six times.

Test Plan:
- Reset while i_valid = 1 and i_x = 0x123456 → o_valid = 0, o_z = 0, o_zero = 0 asynchronously; no output appears for that sample.
- Walking one: i_x = 1<<k for k = 23..0 on consecutive cycles → o_z = 23−k each cycle, o_valid continuously 1 after the latency.
- i_x = 0x000000 → o_z = 24, o_zero = 1. Then i_x = 0xFFFFFF → o_z = 0, o_zero = 0.
- Nibble boundaries:
  - i_x = 0x0F0000 → 4
  - i_x = 0x00F000 → 8
  - i_x = 0x000008 → 20
  - i_x = 0x0007FF → 13
- Q12.12 reciprocal use: i_x = 0x001000 (1.0) → 11; 0x000800 (0.5) → 12; 0x800000 → 0.
- Gapped valid: pattern 1,0,1,1 with values 0x400000, X, 0x000003, 0x010000 → outputs 1, 22, 7 in order. o_z holds its last value during the gap. Run in both LZC24_PIPE_EN builds and check the latency difference.
